// File: rtl/keccak_absorb_padder.sv
// keccak_absorb_padder: turns a 64-bit message word stream into rate-aligned sponge lanes with suffix and pad10*1.
module keccak_absorb_padder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  rate_words,
    input  logic [7:0]  suffix,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic [3:0]  in_nbytes,
    input  logic        in_last,
    output logic        in_ready,
    output logic        absorb_valid,
    output logic [63:0] absorb_data,
    output logic        absorb_last,
    input  logic        absorb_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, DATA, PAD, FLUSH} state_t;
    state_t      state, state_n;
    logic [4:0]  lane_cnt, rate_q;
    logic [7:0]  suffix_q;
    logic        suffix_pend, pend_n, load, load_last, done_n;
    logic        slot_free, final_lane, partial;
    logic [3:0]  eff_n;
    logic [63:0] part_word, load_data;
    assign slot_free  = !absorb_valid || absorb_ready;
    assign final_lane = lane_cnt == rate_q - 5'd1;
    assign partial    = in_last && in_nbytes < 4'd8;
    assign eff_n      = partial ? in_nbytes : 4'd8;
    assign in_ready   = state == DATA && slot_free;
    assign busy       = state != IDLE;
    // Full words pass through unchanged since eff_n=8 keeps every byte.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_byte
            assign part_word[8*i+:8] = 4'(i) < eff_n ? in_data[8*i+:8] :
                                       4'(i) == eff_n ? suffix_q : 8'h00;
        end
    endgenerate
    always_comb begin
        state_n   = state;
        pend_n    = suffix_pend;
        load      = 1'b0;
        load_last = 1'b0;
        load_data = part_word;
        done_n    = 1'b0;
        case (state)
            IDLE: state_n = start ? DATA : IDLE;
            DATA: if (in_valid && slot_free) begin
                load      = 1'b1;
                load_last = partial && final_lane;
                load_data = part_word | {load_last ? 8'h80 : 8'h00, 56'h0};
                state_n   = load_last ? FLUSH : in_last ? PAD : DATA;
                pend_n    = !partial;
            end
            PAD: if (slot_free) begin
                load      = 1'b1;
                load_last = final_lane;
                load_data = {final_lane ? 8'h80 : 8'h00, 48'h0, suffix_pend ? suffix_q : 8'h00};
                pend_n    = 1'b0;
                state_n   = final_lane ? FLUSH : PAD;
            end
            FLUSH: if (absorb_valid && absorb_ready && absorb_last) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lane_cnt     <= '0;
            rate_q       <= '0;
            suffix_q     <= '0;
            suffix_pend  <= 1'b0;
            absorb_valid <= 1'b0;
            absorb_data  <= '0;
            absorb_last  <= 1'b0;
            done         <= 1'b0;
        end else begin
            state       <= state_n;
            suffix_pend <= pend_n;
            done        <= done_n;
            if (state == IDLE && start) begin
                rate_q   <= rate_words;
                suffix_q <= suffix;
                lane_cnt <= '0;
            end
            if (load) begin
                absorb_valid <= 1'b1;
                absorb_data  <= load_data;
                absorb_last  <= load_last;
                lane_cnt     <= final_lane ? 5'd0 : lane_cnt + 5'd1;
            end else if (absorb_ready) begin
                absorb_valid <= 1'b0;
                absorb_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keccak_absorb_padder.sv
// tb_keccak_absorb_padder: directed vectors with hand-computed lanes, optional random sink backpressure.
module tb_keccak_absorb_padder;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [4:0]  rate_words = 0;
    logic [7:0]  suffix = 0;
    logic        in_valid = 0, in_last = 0, absorb_ready = 1;
    logic [63:0] in_data = 0;
    logic [3:0]  in_nbytes = 0;
    logic        in_ready, absorb_valid, absorb_last, busy, done;
    logic [63:0] absorb_data;
    int n_cmp = 0, n_err = 0, done_cnt = 0;
    bit stall_mode = 0;
    logic [63:0] got_d[$], exp_d[$], msg_d[$], stall_ref[$];
    logic        got_l[$], msg_l[$];
    logic [3:0]  msg_n[$];
    localparam logic [63:0] TOP = 64'h8000000000000000;

    keccak_absorb_padder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rate_words(rate_words), .suffix(suffix),
        .in_valid(in_valid), .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
        .in_ready(in_ready), .absorb_valid(absorb_valid), .absorb_data(absorb_data),
        .absorb_last(absorb_last), .absorb_ready(absorb_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        absorb_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Sample mid-cycle: values seen here are what the next rising edge acts on.
    initial begin
        logic        p_stall = 0, p_last = 0;
        logic [63:0] p_data = 0;
        forever begin
            @(negedge clk);
            #1;
            if (p_stall && rst_n) begin
                check("stall_valid", 64'(absorb_valid), 64'd1);
                check("stall_data", absorb_data, p_data);
                check("stall_last", 64'(absorb_last), 64'(p_last));
            end
            if (absorb_valid && !absorb_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            p_stall = absorb_valid && !absorb_ready;
            p_data  = absorb_data;
            p_last  = absorb_last;
            if (absorb_valid && absorb_ready) begin
                got_d.push_back(absorb_data);
                got_l.push_back(absorb_last);
            end
            if (done) done_cnt++;
        end
    end

    task automatic begin_msg(input logic [4:0] r, input logic [7:0] s);
        got_d.delete(); got_l.delete();
        @(negedge clk);
        start = 1; rate_words = r; suffix = s;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] n, input logic l);
        int  t = 0;
        logic acc = 0;
        @(negedge clk);
        in_valid = 1; in_data = d; in_nbytes = n; in_last = l;
        do begin
            #1;
            acc = in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
            t++;
        end while (!acc && t < 200);
        if (!acc) check("in_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_msg(input string name, input logic [4:0] r, input logic [7:0] s);
        int d0, t;
        d0 = done_cnt;
        t = 0;
        begin_msg(r, s);
        foreach (msg_d[k]) send_word(msg_d[k], msg_n[k], msg_l[k]);
        @(negedge clk);
        in_valid = 0; in_last = 0;
        while (done_cnt == d0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check({name, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({name, " busy_after"}, 64'(busy), 64'd0);
        check({name, " lane_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            check($sformatf("%s lane%0d data", name, k), got_d[k], exp_d[k]);
            check($sformatf("%s lane%0d last", name, k), 64'(got_l[k]), 64'(k == exp_d.size() - 1));
        end
    endtask

    task automatic clear_vec();
        msg_d.delete(); msg_n.delete(); msg_l.delete(); exp_d.delete();
    endtask

    task automatic add_word(input logic [63:0] d, input logic [3:0] n, input logic l);
        msg_d.push_back(d); msg_n.push_back(n); msg_l.push_back(l);
    endtask

    task automatic build_case3();
        clear_vec();
        for (int k = 0; k < 17; k++) begin
            add_word({32'hA5A50000 + 32'(k), 32'h12340000 + 32'(k * 3)}, 4'd8, k == 16);
            exp_d.push_back({32'hA5A50000 + 32'(k), 32'h12340000 + 32'(k * 3)});
        end
        exp_d.push_back(64'h06);
        for (int k = 1; k < 16; k++) exp_d.push_back(64'h0);
        exp_d.push_back(TOP);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst absorb_valid", 64'(absorb_valid), 64'd0);
        check("rst absorb_data", absorb_data, 64'd0);
        check("rst absorb_last", 64'(absorb_last), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        rst_n = 1;

        clear_vec();
        add_word(64'h0, 4'd0, 1);
        exp_d.push_back(64'h1F);
        for (int k = 1; k < 20; k++) exp_d.push_back(64'h0);
        exp_d.push_back(TOP);
        run_msg("empty_r21", 5'd21, 8'h1F);

        clear_vec();
        add_word(64'h636261, 4'd3, 1);
        exp_d.push_back(64'h0000000006636261);
        for (int k = 1; k < 16; k++) exp_d.push_back(64'h0);
        exp_d.push_back(TOP);
        run_msg("abc_r17", 5'd17, 8'h06);

        build_case3();
        run_msg("full_r17", 5'd17, 8'h06);

        clear_vec();
        for (int k = 0; k < 16; k++) begin
            add_word(64'h1111111111111111 * 64'(k + 1), 4'd8, 0);
            exp_d.push_back(64'h1111111111111111 * 64'(k + 1));
        end
        add_word(64'h00AABBCCDDEEFF11, 4'd7, 1);
        exp_d.push_back(64'h86AABBCCDDEEFF11);
        run_msg("n7_r17", 5'd17, 8'h06);

        stall_mode = 1;
        build_case3();
        run_msg("stall_r17", 5'd17, 8'h06);
        stall_mode = 0;

        clear_vec();
        add_word(64'h0, 4'd0, 1);
        exp_d.push_back(64'h8000000000000006);
        run_msg("empty_r1", 5'd1, 8'h06);

        clear_vec();
        add_word(64'h0123456789ABCDEF, 4'd8, 1);
        exp_d.push_back(64'h0123456789ABCDEF);
        exp_d.push_back(64'h8000000000000006);
        run_msg("full_r1", 5'd1, 8'h06);

        begin
            int t = 0;
            begin_msg(5'd21, 8'h1F);
            send_word(64'h0, 4'd0, 1);
            @(negedge clk);
            in_valid = 0; in_last = 0;
            while (got_d.size() < 5 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("pad_reached", 64'(got_d.size() >= 5), 64'd1);
            #3 rst_n = 0;
            #1;
            check("mid_rst absorb_valid", 64'(absorb_valid), 64'd0);
            check("mid_rst absorb_data", absorb_data, 64'd0);
            check("mid_rst absorb_last", 64'(absorb_last), 64'd0);
            check("mid_rst busy", 64'(busy), 64'd0);
            @(negedge clk);
            rst_n = 1;
            got_d.delete(); got_l.delete();
            in_valid = 1; in_data = '1; in_nbytes = 4'd8; in_last = 0;
            repeat (8) begin
                @(negedge clk);
                #1;
                check("no_start in_ready", 64'(in_ready), 64'd0);
            end
            in_valid = 0;
            repeat (2) @(negedge clk);
            check("no_start lanes", 64'(got_d.size()), 64'd0);
        end

        clear_vec();
        add_word(64'h636261, 4'd3, 1);
        exp_d.push_back(64'h0000000006636261);
        for (int k = 1; k < 16; k++) exp_d.push_back(64'h0);
        exp_d.push_back(TOP);
        run_msg("after_rst", 5'd17, 8'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/keccak_absorb_padder.md
Name: keccak_absorb_padder

Overview:
- Producer for the Keccak sponge absorb interface: takes a 64-bit-word message stream and emits rate-aligned lanes with domain-separation suffix and pad10*1 applied.
- Asserts absorb_last only on lane rate_words-1 of the final block, so the sponge receives complete, padded blocks.
- Sits between the message source (SHAKE/SHA3 front end, sampler seed logic) and the sponge's absorb_valid/absorb_data/absorb_ready/absorb_last port.

Parameters:
- none (rate and suffix are per-message run-time inputs)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  begin new message; sampled only in IDLE
- rate_words  in  5  lanes per block (r/64), legal 1..21; latched on start
- suffix  in  8  domain bits incl. first pad 1 (0x1F SHAKE, 0x06 SHA3); legal 0x01..0x7F; latched on start
- in_valid  in  1  message word valid
- in_data  in  64  message bytes, little-endian: byte k at [8k+7:8k]
- in_nbytes  in  4  valid bytes 0..8; <8 legal only with in_last
- in_last  in  1  final message word (nbytes=0 means empty tail)
- in_ready  out  1  word accepted when in_valid && in_ready
- absorb_valid  out  1  lane valid to sponge
- absorb_data  out  64  lane to sponge
- absorb_last  out  1  final lane of final block
- absorb_ready  in  1  sponge ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final lane accepted

Behaviour:
- Reset: IDLE, lane_cnt=0, absorb_valid=0, absorb_data=0, absorb_last=0, in_ready=0, done=0, busy=0; latched cfg cleared. Reset mid-message abandons it; a new start is required.
- Output stage is a single register; slot_free = !absorb_valid || absorb_ready. Loading into a free slot sets absorb_valid; a transfer without reload clears it. absorb_data/last stay stable while absorb_valid && !absorb_ready.
- lane_cnt = lane index of the next word loaded; it increments on each load and wraps to 0 after rate_words-1. final_lane = (lane_cnt == rate_words-1).
- IDLE: start -> latch rate_words/suffix, lane_cnt=0, go to DATA. start outside IDLE is ignored.
- DATA: in_ready = slot_free. On accept, the loaded word depends on the input:
  - Not last (nbytes must be 8): load in_data unchanged, absorb_last=0.
  - in_last, nbytes=n<8: bytes 0..n-1 of in_data kept, bytes above n zeroed, byte n = suffix.
    - If final_lane: OR 0x80 into byte 7, set absorb_last=1, go to FLUSH.
    - Otherwise go to PAD with suffix_pend=0.
  - in_last, nbytes=8: load in_data unchanged, go to PAD with suffix_pend=1.
- PAD: in_ready=0. On each slot_free cycle, load the pad word: byte0 = suffix if suffix_pend else 0, OR (0x80<<56) if final_lane. suffix_pend clears after the first pad word. When final_lane, set absorb_last=1 and go to FLUSH.
- Collisions in byte 7: suffix and 0x80 share byte 7 when n=7 on the final lane (0x06 -> 0x86). With rate_words=1 the pad word carries both suffix (byte 0) and 0x80 (byte 7).
- FLUSH: wait until the last lane transfers (absorb_valid && absorb_ready && absorb_last), then pulse done for 1 cycle and return to IDLE with lane_cnt=0.
- Latency: input word to absorb_valid is 1 cycle; full throughput of 1 word/cycle when absorb_ready is held high.
- Total lanes emitted is always a multiple of rate_words; exactly one absorb_last per message.
- Illegal nbytes>8 or nbytes<8 without last: treated as 8; outside the verification scope beyond no-hang.

Test Plan:
- rate 21, suffix 0x1F, empty message (in_last, nbytes=0) -> 21 lanes: L0=0x1F, L1..L19=0, L20=0x8000000000000000 with absorb_last; done pulses once.
- rate 17, suffix 0x06, in_data=0x636261 nbytes=3 -> L0=0x0000000006636261, L1..L15=0, L16=0x8000000000000000 last; 17 lanes total.
- rate 17, 17 full words D0..D16 then an empty tail (or last on D16, nbytes=8) -> D0..D16 passed unchanged with no last; then L0=0x06, zeros, L16=0x80<<56 last; 34 lanes total.
- rate 17, 16 full words + last word nbytes=7 data 0x00AABBCCDDEEFF11 -> lane 16 = 0x86AABBCCDDEEFF11 with absorb_last; no extra block.
- Random absorb_ready backpressure over case 3 -> absorb_data stable while stalled; in_ready low when the slot is full and not ready; lane sequence identical to the no-stall run.
- Assert rst_n low during PAD -> all outputs 0 immediately; in_valid is ignored until start; the next message is correct from lane 0.
